ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
- Parametrised successor to the team's single-event PS/2 keyboard decoder, for scan-code set 2.
- Consumes the byte stream from the PS/2 byte receiver and decodes the E0 (extend) and F0 (break) prefixes.
- Maintains a 512-bit key-state map and queues make/break events in a FIFO, read through a valid/ready handshake.
- Adds beyond the previous generation: repeat filtering, a pressed-key count, prefix timeout, overflow reporting and BAT detection.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 2_000_000, maximum clk cycles allowed between the bytes of a multi-byte sequence.
REPEAT_FILTER, 1, 1 = suppress typematic repeats and spurious breaks; 0 = queue every decoded code.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
byte_in  in  8  received scan byte
byte_valid  in  1  one-cycle strobe; byte_in is valid in that cycle
key_down  out  512  bit {ext,code} is 1 while that key is held
num_down  out  9  number of set bits in key_down
evt_code  out  9  head event code {ext, code[7:0]}
evt_break  out  1  head event: 1 = release, 0 = press
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer pops the head when evt_valid && evt_ready
overflow  out  1  sticky: an event was dropped
clr_ovf  in  1  clears overflow
bat_ok  out  1  one-cycle pulse when keyboard self-test passes (0xAA)
seq_err  out  1  one-cycle pulse on prefix timeout or illegal prefix order

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: key_down=0, num_down=0, FIFO empty, evt_valid=0, overflow=0, bat_ok=0, seq_err=0, FSM in IDLE, timeout counter 0.
- rst asserted mid-sequence discards any partial prefix. No event is generated for keys held at the time of reset.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; AA -> pulse bat_ok, clear key_down and num_down, no event; any other byte -> make event {0, byte}.
  - EXT: F0 -> EXT_BRK; E0 -> seq_err, stay in EXT; other byte -> make event {1, byte}, go to IDLE.
  - BRK: E0 or F0 -> seq_err, go to IDLE, byte dropped; other byte -> break event {0, byte}, go to IDLE.
  - EXT_BRK: E0 or F0 -> seq_err, go to IDLE; other byte -> break event {1, byte}, go to IDLE.
- Timeout: the counter runs while the FSM is not in IDLE and reloads on every byte_valid. When it reaches TIMEOUT_CYCLES-1: seq_err pulse, go to IDLE.
- Key-state update for a decoded event with code c:
  - Make sets key_down[c]; break clears key_down[c].
  - key_down and num_down change in the cycle after the final byte's strobe (latency 1).
  - num_down increments or decrements only when the bit actually changes, so it never wraps.
- Repeat filter:
  - REPEAT_FILTER=1: a make for a key already down, or a break for a key already up, updates nothing and pushes nothing.
  - REPEAT_FILTER=0: such events are pushed anyway; key_down and num_down stay consistent because they track bit changes only.
- FIFO:
  - First-word-fall-through; each entry is {break, code[8:0]}.
  - An accepted push makes evt_valid=1 one cycle after the final byte's strobe when the FIFO was empty.
  - A pop occurs when evt_valid && evt_ready; the next entry is presented in the following cycle.
- Full FIFO: fullness is judged before any same-cycle pop, so a push while full is dropped even if a pop occurs in the same cycle. A dropped push sets overflow; key_down is still updated.
- Simultaneous push and pop when not full: both happen and the occupancy count is unchanged.
- Pop when empty is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: clr_ovf clears it; a drop in the same cycle as clr_ovf wins, leaving overflow=1.

Optional Feature:
- PS2_PAUSE_KEY_EN defined:
  - E1 in IDLE enters a PAUSE state that matches the remaining 7 bytes: 14 77 E1 F0 14 F0 77.
  - On a full match: push make then break for code 9'h100 (two FIFO pushes on consecutive cycles); key_down is not changed.
  - On a mismatch or timeout: seq_err pulse, go to IDLE.
- Not defined: E1 in IDLE produces a seq_err pulse and is discarded. The following bytes decode normally (14/77 presses and releases).

Decomposition:
- Package ps2_pkg:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA;
  - FSM state enum;
  - event typedef {logic brk; logic [8:0] code};
  - PAUSE_CODE=9'h100.
- Sub-module ps2_event_fifo (parametrised depth and width, FWFT, with full/empty and a drop indication) is instantiated once.

Test Plan:
- Bytes 1C, then F0 1C -> event {0,01C} then {1,01C}; key_down[0x01C] goes 1 then 0; num_down goes 1 then 0.
- Bytes E0 75, then E0 F0 75 -> events {0,175}, {1,175}; key_down[0x175] toggles 1 then 0.
- REPEAT_FILTER=1, byte 1C sent 5 times -> exactly one event and num_down=1. Same with REPEAT_FILTER=0 -> 5 events and num_down=1.
- FIFO_DEPTH=4, evt_ready=0, 6 distinct makes -> 4 entries queued, overflow=1, num_down=6. Then clr_ovf -> overflow=0; drain returns the first 4 codes in order.
- Byte E0, then idle for TIMEOUT_CYCLES -> single seq_err pulse; a following 1C gives {0,01C}, not {1,01C}.
- Byte AA with 3 keys held -> bat_ok pulse, key_down=0, num_down=0, no event. With PS2_PAUSE_KEY_EN, the 8-byte Pause sequence -> events {0,100} then {1,100}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared byte constants, FSM states and event type for the PS/2 key event decoder
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT = 8'hAA;
  localparam logic [8:0] PAUSE_CODE = 9'h100;
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;
  typedef struct packed {
    logic brk;
    logic [8:0] code;
  } evt_t;
  // bytes that must follow the leading E1 of the Pause key sequence
  function automatic logic [7:0] pause_byte(input logic [2:0] i);
    return i == 3'd0 ? 8'h14 : i == 3'd1 ? 8'h77 : i == 3'd2 ? 8'hE1 : i == 3'd3 ? 8'hF0 :
           i == 3'd4 ? 8'h14 : i == 3'd5 ? 8'hF0 : 8'h77;
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through FIFO; a push while full is dropped and flagged
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign drop = push && full;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr] <= din;
endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: set-2 scan bytes to key map, pressed count and make/break event FIFO.
// Define PS2_PAUSE_KEY_EN to decode the 8-byte Pause sequence into code 9'h100.
import ps2_pkg::*;
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int REPEAT_FILTER = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic [511:0] key_down,
  output logic [8:0]   num_down,
  output logic [8:0]   evt_code,
  output logic         evt_break,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic         overflow,
  input  logic         clr_ovf,
  output logic         bat_ok,
  output logic         seq_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic tout, dec, dec_brk, chg, push, err, bat, pdone, pend, full_unused, empty, drop;
  logic [8:0] dec_code;
  evt_t din, dout;
`ifdef PS2_PAUSE_KEY_EN
  logic [2:0] pidx;
`endif
  assign tout = state != ST_IDLE && !byte_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nxt = state;
    dec = 1'b0;
    dec_brk = state == ST_BRK || state == ST_EXT_BRK;
    dec_code = {state == ST_EXT || state == ST_EXT_BRK, byte_in};
    err = 1'b0;
    bat = 1'b0;
    pdone = 1'b0;
    if (tout) begin
      nxt = ST_IDLE;
      err = 1'b1;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_in == PS2_EXT) nxt = ST_EXT;
          else if (byte_in == PS2_BRK) nxt = ST_BRK;
          else if (byte_in == PS2_BAT) bat = 1'b1;
`ifdef PS2_PAUSE_KEY_EN
          else if (byte_in == PS2_PAUSE) nxt = ST_PAUSE;
`else
          else if (byte_in == PS2_PAUSE) err = 1'b1;
`endif
          else dec = 1'b1;
        end
        ST_EXT: begin
          if (byte_in == PS2_BRK) nxt = ST_EXT_BRK;
          else if (byte_in == PS2_EXT) err = 1'b1;
          else begin
            dec = 1'b1;
            nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          nxt = ST_IDLE;
          err = byte_in == PS2_EXT || byte_in == PS2_BRK;
          dec = !err;
        end
        default: begin
`ifdef PS2_PAUSE_KEY_EN
          err = byte_in != pause_byte(pidx);
          pdone = !err && pidx == 3'd6;
          nxt = err || pdone ? ST_IDLE : ST_PAUSE;
`else
          nxt = ST_IDLE;
`endif
        end
      endcase
    end
  end
  // a decoded key event takes the FIFO slot first; the Pause release waits behind it
  assign chg = dec && key_down[dec_code] == dec_brk;
  assign push = dec ? (chg || REPEAT_FILTER == 0) : (pdone || pend);
  assign din = dec ? {dec_brk, dec_code} : {!pdone, PAUSE_CODE};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tcnt <= '0;
      key_down <= '0;
      num_down <= '0;
      bat_ok <= 1'b0;
      seq_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      tcnt <= byte_valid || state == ST_IDLE ? '0 : tcnt + 1'b1;
      bat_ok <= bat;
      seq_err <= err;
      overflow <= drop || (overflow && !clr_ovf);
      if (bat) begin
        key_down <= '0;
        num_down <= '0;
      end else if (chg) begin
        key_down[dec_code] <= !dec_brk;
        num_down <= dec_brk ? num_down - 1'b1 : num_down + 1'b1;
      end
    end
  end
`ifdef PS2_PAUSE_KEY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      pidx <= '0;
    end else begin
      pend <= pdone || (pend && dec);
      pidx <= nxt != ST_PAUSE ? '0 : pidx + 3'(state == ST_PAUSE && byte_valid);
    end
  end
`else
  assign pend = 1'b0;
`endif
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(evt_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(evt_ready),
    .din(din),
    .dout(dout),
    .full(full_unused),
    .empty(empty),
    .drop(drop)
  );
  assign evt_valid = !empty;
  assign evt_code = dout.code;
  assign evt_break = dout.brk;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: random and directed scan-byte stimulus against a key/event-level model,
// driving one filtering (dut0) and one non-filtering (dut1) decoder with the same byte stream.
module tb_ps2_key_event_decoder;
  localparam int D = 4;
  localparam int TO = 40;
  logic clk, rst, byte_valid, evt_ready, clr_ovf;
  logic [7:0] byte_in;
  logic [511:0] kd [2];
  logic [8:0] nd [2];
  logic [8:0] ec [2];
  logic eb [2];
  logic ev_v [2];
  logic ovf [2];
  logic bo [2];
  logic se [2];
  int checks = 0;
  int failures = 0;
  int r_kind;
  logic r_brk, r_err, r_mid;
  logic [8:0] r_code;
  bit [511:0] km [2];
  logic [9:0] qm [2][64];
  int qh [2];
  int qt [2];
  bit m_ovf [2];
  bit e_err, e_bat, m_mid;
  int gap;
  int dut_pops [2];
  int err_seen [2];
  logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B, 8'h74, 8'h72};
  logic [7:0] ovf_codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

  ps2_key_event_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO), .REPEAT_FILTER(1)) u_dut0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .key_down(kd[0]),
    .num_down(nd[0]), .evt_code(ec[0]), .evt_break(eb[0]), .evt_valid(ev_v[0]),
    .evt_ready(evt_ready), .overflow(ovf[0]), .clr_ovf(clr_ovf), .bat_ok(bo[0]), .seq_err(se[0]));
  ps2_key_event_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO), .REPEAT_FILTER(0)) u_dut1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .key_down(kd[1]),
    .num_down(nd[1]), .evt_code(ec[1]), .evt_break(eb[1]), .evt_valid(ev_v[1]),
    .evt_ready(evt_ready), .overflow(ovf[1]), .clr_ovf(clr_ovf), .bat_ok(bo[1]), .seq_err(se[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // key-event-level model: r_kind 1 = key event, 2 = self-test pass, 3 = unconditional push
  task automatic model_step();
    logic [9:0] ent;
    bit push, chg, drop;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        km[i] = '0;
        qh[i] = 0;
        qt[i] = 0;
        m_ovf[i] = 0;
      end
      e_err = 0;
      e_bat = 0;
      m_mid = 0;
      gap = 0;
    end else begin
      e_bat = r_kind == 2;
      e_err = r_err;
      if (byte_valid) begin
        m_mid = r_mid;
        gap = 0;
      end else if (m_mid) begin
        gap++;
        if (gap == TO) begin
          e_err = 1;
          m_mid = 0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        push = 0;
        ent = {r_brk, r_code};
        if (r_kind == 1) begin
          chg = r_brk ? km[i][r_code] : !km[i][r_code];
          if (chg) km[i][r_code] = !r_brk;
          push = chg || i == 1;
        end else if (r_kind == 2) km[i] = '0;
        else if (r_kind == 3) push = 1;
        drop = push && (qt[i] - qh[i] == D);
        if (drop) m_ovf[i] = 1;
        else if (clr_ovf) m_ovf[i] = 0;
        if (evt_ready && qt[i] != qh[i]) qh[i]++;
        if (push && !drop) begin
          qm[i][qt[i] % 64] = ent;
          qt[i]++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d key_down", i), kd[i], km[i]);
      chk($sformatf("dut%0d num_down", i), 512'(nd[i]), 512'($countones(km[i])));
      chk($sformatf("dut%0d evt_valid", i), 512'(ev_v[i]), 512'(qt[i] != qh[i]));
      if (qt[i] != qh[i]) chk($sformatf("dut%0d evt_head", i), 512'({eb[i], ec[i]}), 512'(qm[i][qh[i] % 64]));
      chk($sformatf("dut%0d overflow", i), 512'(ovf[i]), 512'(m_ovf[i]));
      chk($sformatf("dut%0d seq_err", i), 512'(se[i]), 512'(e_err));
      chk($sformatf("dut%0d bat_ok", i), 512'(bo[i]), 512'(e_bat));
      if (ev_v[i] && evt_ready) dut_pops[i]++;
      if (se[i]) err_seen[i]++;
    end
  end

  task automatic send(input logic [7:0] b, input int kind, input logic brk, input logic [8:0] code,
                      input logic err, input logic mid);
    byte_in = b;
    byte_valid = 1'b1;
    r_kind = kind;
    r_brk = brk;
    r_code = code;
    r_err = err;
    r_mid = mid;
    @(posedge clk);
    #2;
    byte_valid = 1'b0;
    r_kind = 0;
    r_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic x, input logic [7:0] c);
    if (x) send(8'hE0, 0, 0, 9'h0, 0, 1);
    send(c, 1, 0, {x, c}, 0, 0);
  endtask

  task automatic release_key(input logic x, input logic [7:0] c);
    if (x) send(8'hE0, 0, 0, 9'h0, 0, 1);
    send(8'hF0, 0, 0, 9'h0, 0, 1);
    send(c, 1, 1, {x, c}, 0, 0);
  endtask

  initial begin
    int m0, m1, e0, sel;
    logic [7:0] c;
    logic x;
    rst = 1'b1;
    byte_in = '0;
    byte_valid = 1'b0;
    evt_ready = 1'b1;
    clr_ovf = 1'b0;
    r_kind = 0;
    r_brk = 1'b0;
    r_code = '0;
    r_err = 1'b0;
    r_mid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset num_down", 512'(nd[0]), 512'(0));
    chk("reset evt_valid", 512'(ev_v[0]), 512'(0));
    chk("reset overflow", 512'(ovf[1]), 512'(0));
    chk("reset key_down", kd[1], 512'(0));
    press(0, 8'h1C);
    chk("make 1C head", 512'({eb[0], ec[0]}), 512'(10'h01C));
    chk("make 1C num_down", 512'(nd[0]), 512'(1));
    chk("make 1C key bit", 512'(kd[0][9'h01C]), 512'(1));
    release_key(0, 8'h1C);
    chk("break 1C head", 512'({eb[0], ec[0]}), 512'(10'h21C));
    chk("break 1C num_down", 512'(nd[0]), 512'(0));
    press(1, 8'h75);
    chk("make E0 75 head", 512'({eb[0], ec[0]}), 512'(10'h175));
    chk("make E0 75 key bit", 512'(kd[0][9'h175]), 512'(1));
    release_key(1, 8'h75);
    chk("break E0 75 head", 512'({eb[1], ec[1]}), 512'(10'h375));
    chk("break E0 75 key bit", 512'(kd[1][9'h175]), 512'(0));
    idle(3);
    m0 = dut_pops[0];
    m1 = dut_pops[1];
    repeat (5) begin
      press(0, 8'h1C);
      idle(2);
    end
    idle(3);
    chk("repeat filtered events", 512'(dut_pops[0] - m0), 512'(1));
    chk("repeat unfiltered events", 512'(dut_pops[1] - m1), 512'(5));
    chk("repeat num_down rf1", 512'(nd[0]), 512'(1));
    chk("repeat num_down rf0", 512'(nd[1]), 512'(1));
    release_key(0, 8'h1C);
    idle(3);
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) press(0, ovf_codes[k]);
    chk("full num_down", 512'(nd[0]), 512'(6));
    chk("full overflow", 512'(ovf[0]), 512'(1));
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("cleared overflow", 512'(ovf[0]), 512'(0));
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain %0d", k), 512'({eb[0], ec[0]}), 512'({2'b00, ovf_codes[k]}));
      idle(1);
    end
    chk("drained", 512'(ev_v[0]), 512'(0));
    e0 = err_seen[0];
    send(8'hE0, 0, 0, 9'h0, 0, 1);
    idle(TO + 3);
    chk("timeout pulses", 512'(err_seen[0] - e0), 512'(1));
    press(0, 8'h1C);
    chk("after timeout head", 512'({eb[0], ec[0]}), 512'(10'h01C));
    idle(3);
    send(8'hAA, 2, 0, 9'h0, 0, 0);
    chk("bat pulse", 512'(bo[0]), 512'(1));
    chk("bat num_down", 512'(nd[0]), 512'(0));
    idle(2);
    send(8'hE0, 0, 0, 9'h0, 0, 1);
    send(8'hE0, 0, 0, 9'h0, 1, 1);
    chk("E0 E0 seq_err", 512'(se[0]), 512'(1));
    send(8'h75, 1, 0, 9'h175, 0, 0);
    chk("E0 E0 75 head", 512'({eb[0], ec[0]}), 512'(10'h175));
    send(8'hF0, 0, 0, 9'h0, 0, 1);
    send(8'hE0, 0, 0, 9'h0, 1, 0);
    send(8'h75, 1, 0, 9'h075, 0, 0);
    chk("F0 E0 75 head", 512'({eb[0], ec[0]}), 512'(10'h075));
    send(8'hE0, 0, 0, 9'h0, 0, 1);
    send(8'hF0, 0, 0, 9'h0, 0, 1);
    send(8'hF0, 0, 0, 9'h0, 1, 0);
    idle(3);
`ifdef PS2_PAUSE_KEY_EN
    evt_ready = 1'b0;
    send(8'hE1, 0, 0, 9'h0, 0, 1);
    send(8'h14, 0, 0, 9'h0, 0, 1);
    send(8'h77, 0, 0, 9'h0, 0, 1);
    send(8'hE1, 0, 0, 9'h0, 0, 1);
    send(8'hF0, 0, 0, 9'h0, 0, 1);
    send(8'h14, 0, 0, 9'h0, 0, 1);
    send(8'hF0, 0, 0, 9'h0, 0, 1);
    send(8'h77, 3, 0, 9'h100, 0, 0);
    r_kind = 3;
    r_brk = 1'b1;
    r_code = 9'h100;
    @(posedge clk);
    #2 r_kind = 0;
    chk("pause make head", 512'({eb[0], ec[0]}), 512'(10'h100));
    evt_ready = 1'b1;
    idle(1);
    chk("pause break head", 512'({eb[0], ec[0]}), 512'(10'h300));
    idle(2);
`else
    send(8'hE1, 0, 0, 9'h0, 1, 0);
    chk("E1 seq_err", 512'(se[0]), 512'(1));
    idle(2);
`endif
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      c = pool[$urandom_range(0, 7)];
      x = 1'($urandom_range(0, 1));
      evt_ready = $urandom_range(0, 99) < 60;
      clr_ovf = $urandom_range(0, 99) < 10;
      if (sel < 3) send(8'hAA, 2, 0, 9'h0, 0, 0);
      else if (sel < 55) press(x, c);
      else release_key(x, c);
      clr_ovf = 1'b0;
      idle($urandom_range(0, 3));
    end
    evt_ready = 1'b1;
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
